pkt_capt_ingress: RTL and testbench
===================================

Name: pkt_capt_ingress

Overview:
- Store-and-forward capture front end sitting directly upstream of the capture-buffer write controller.
- Passively taps a 32-bit Avalon-ST packet stream and writes each accepted packet's words into the shared packet FIFO.
- Latches the SOP timestamp and, once the packet is complete in the FIFO, issues a one-cycle `wr_ctrl` request with the packet byte span.
- Holds off all new captures until the write controller signals completion.

Parameters:
- FIFO_DEPTH, 512: packet FIFO depth in 32-bit words.
- MAX_PKT_BYTES, 1536: hard cap on captured bytes per packet; must be ≤ FIFO_DEPTH*4.
- CNT_W, 32: width of statistics counters.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- asi_data  in  32  tapped stream data, first byte in [31:24]
- asi_valid  in  1  beat valid (tap: no backpressure)
- asi_startofpacket  in  1  SOP
- asi_endofpacket  in  1  EOP
- asi_empty  in  2  unused bytes on EOP beat
- capt_en  in  1  capture enable, sampled at SOP
- snaplen  in  16  per-packet byte limit; 0 = MAX_PKT_BYTES
- time_sec  in  32  free-running seconds
- time_nsec  in  32  free-running nanoseconds
- fifo_data  out  32  FIFO write data
- fifo_wrreq  out  1  FIFO write strobe
- fifo_full  in  1  FIFO full
- wr_ctrl  out  1  one-cycle packet-ready request
- wr_ctrl_rdy  in  1  one-cycle packet-done pulse from write controller
- pkt_begin  out  32  packet start byte offset (always 0)
- pkt_end  out  32  captured byte count
- seconds  out  32  SOP timestamp, seconds
- nanoseconds  out  32  SOP timestamp, nanoseconds
- busy  out  1  a packet is pending or in flight
- pkt_count  out  CNT_W  packets handed off
- drop_count  out  CNT_W  packets dropped
- trunc_count  out  CNT_W  packets truncated

Behaviour:
- Reset: all outputs 0; state IDLE.
- Clocking: all registers on `clk`, async clear on `reset`.
- Beat definition: a beat is any cycle with asi_valid=1. Beats without asi_valid are ignored, including their SOP/EOP.
- Byte limit: lim = (snaplen==0 || snaplen>MAX_PKT_BYTES) ? MAX_PKT_BYTES : snaplen, latched at SOP.
- IDLE:
  - SOP beat with capt_en=1 → CAPTURE. Latch time_sec/time_nsec into shadow registers, clear byte counter, and write this beat.
  - SOP beat with capt_en=0 → DISCARD, no count.
- CAPTURE, per beat:
  - Beat bytes = EOP ? 4-asi_empty : 4.
  - If byte_cnt < lim and !fifo_full: fifo_wrreq=1 and fifo_data=asi_data (registered, 1-cycle latency); byte_cnt += min(beat bytes, lim-byte_cnt).
  - Otherwise the beat is consumed, not written, and the truncated flag is set.
  - EOP → HANDOFF.
  - SOP while in CAPTURE (missing EOP): close the current packet with bytes so far, set truncated, go to HANDOFF. The new packet is counted as dropped.
- SOP+EOP on the same beat: single-beat packet, bytes = 4-asi_empty.
- HANDOFF (1 cycle):
  - Copy shadows to seconds/nanoseconds; set pkt_end = byte_cnt and pkt_begin = 0.
  - Pulse wr_ctrl=1 one cycle after the last fifo_wrreq.
  - pkt_count++; trunc_count++ if truncated.
  - → WAIT_RDY.
- WAIT_RDY:
  - seconds, nanoseconds and pkt_end are held stable.
  - Every SOP beat increments drop_count; the packet is not written.
  - wr_ctrl_rdy → IDLE. An SOP on the same cycle as wr_ctrl_rdy is dropped.
- DISCARD: consume beats until EOP → IDLE. A single-beat SOP+EOP stays in IDLE.
- wr_ctrl_rdy outside WAIT_RDY is ignored.
- busy = (state != IDLE && state != DISCARD).
- Counters saturate at all-ones.
- Reset mid-packet: the FIFO is not flushed by this block; the system reset clears it.

Optional Feature:
- Macro PKT_CAPT_STATS_EN.
- Defined: pkt_count, drop_count and trunc_count are implemented as specified.
- Undefined: the counter registers are not built and the three outputs are tied to 0. Capture behaviour is otherwise identical.

Test Plan:
- 64-byte packet (16 beats, empty=0), capt_en=1, snaplen=0 → 16 fifo_wrreq; wr_ctrl pulse 1 cycle after the last write; pkt_end=64; seconds/nanoseconds equal the values at the SOP cycle; pkt_count=1.
- 61-byte packet (EOP empty=3) → 16 writes, pkt_end=61.
- snaplen=20 with a 64-byte packet → 5 writes, pkt_end=20, trunc_count=1.
- Second packet SOP while in WAIT_RDY → no writes, drop_count=1. After wr_ctrl_rdy, a third packet is captured normally.
- SOP without EOP after 3 beats, then a new SOP → pkt_end=12, trunc_count=1, drop_count=1.
- capt_en=0 at SOP → no writes, no wr_ctrl. Then a single beat with SOP+EOP and empty=2, capt_en=1 → 1 write, pkt_end=2.

Source files
------------

// File: rtl/pkt_capt_ingress.sv
// Store-and-forward capture front end: taps an Avalon-ST stream, writes packet words to the
// shared FIFO and hands each packet to the write controller. Statistics counters: PKT_CAPT_STATS_EN.
module pkt_capt_ingress #(
  parameter int FIFO_DEPTH    = 512,
  parameter int MAX_PKT_BYTES = 1536,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      asi_data,
  input  logic             asi_valid,
  input  logic             asi_startofpacket,
  input  logic             asi_endofpacket,
  input  logic [1:0]       asi_empty,
  input  logic             capt_en,
  input  logic [15:0]      snaplen,
  input  logic [31:0]      time_sec,
  input  logic [31:0]      time_nsec,
  output logic [31:0]      fifo_data,
  output logic             fifo_wrreq,
  input  logic             fifo_full,
  output logic             wr_ctrl,
  input  logic             wr_ctrl_rdy,
  output logic [31:0]      pkt_begin,
  output logic [31:0]      pkt_end,
  output logic [31:0]      seconds,
  output logic [31:0]      nanoseconds,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] trunc_count
);

  localparam int BC_W = $clog2(FIFO_DEPTH * 4 + 1);

  typedef enum logic [2:0] {IDLE, CAPTURE, HANDOFF, WAIT_RDY, DISCARD} state_t;

  state_t          state;
  logic [BC_W-1:0] byte_cnt, lim_r;
  logic [31:0]     sec_sh, nsec_sh;
  logic            trunc;

  logic [BC_W-1:0] lim_now, cur_lim, cur_cnt, room, take, beat_w;
  logic [2:0]      beat_bytes;
  logic            can_wr, short_beat, sop_beat;

  assign sop_beat = asi_valid && asi_startofpacket;

  // The SOP beat is evaluated against the limit being latched, with an empty byte count.
  always_comb begin
    if (snaplen == 16'd0 || 32'(snaplen) > MAX_PKT_BYTES) lim_now = BC_W'(MAX_PKT_BYTES);
    else                                                   lim_now = BC_W'(snaplen);
    cur_lim    = (state == IDLE) ? lim_now : lim_r;
    cur_cnt    = (state == IDLE) ? '0 : byte_cnt;
    beat_bytes = asi_endofpacket ? (3'd4 - {1'b0, asi_empty}) : 3'd4;
    beat_w     = BC_W'(beat_bytes);
    room       = cur_lim - cur_cnt;
    can_wr     = (cur_cnt < cur_lim) && !fifo_full;
    take       = (beat_w > room) ? room : beat_w;
    short_beat = !can_wr || (beat_w > room);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      lim_r       <= '0;
      sec_sh      <= '0;
      nsec_sh     <= '0;
      trunc       <= 1'b0;
      fifo_data   <= '0;
      fifo_wrreq  <= 1'b0;
      wr_ctrl     <= 1'b0;
      pkt_end     <= '0;
      seconds     <= '0;
      nanoseconds <= '0;
    end else begin
      fifo_wrreq <= 1'b0;
      wr_ctrl    <= 1'b0;
      case (state)
        IDLE: begin
          if (sop_beat) begin
            if (capt_en) begin
              sec_sh     <= time_sec;
              nsec_sh    <= time_nsec;
              lim_r      <= lim_now;
              byte_cnt   <= can_wr ? take : '0;
              fifo_wrreq <= can_wr;
              if (can_wr) fifo_data <= asi_data;
              trunc      <= short_beat;
              state      <= asi_endofpacket ? HANDOFF : CAPTURE;
            end else if (!asi_endofpacket) begin
              state <= DISCARD;
            end
          end
        end
        CAPTURE: begin
          if (sop_beat) begin
            // Missing EOP: close what we have; the new packet is dropped.
            trunc <= 1'b1;
            state <= HANDOFF;
          end else if (asi_valid) begin
            if (can_wr) begin
              fifo_wrreq <= 1'b1;
              fifo_data  <= asi_data;
              byte_cnt   <= byte_cnt + take;
            end
            if (short_beat)      trunc <= 1'b1;
            if (asi_endofpacket) state <= HANDOFF;
          end
        end
        HANDOFF: begin
          seconds     <= sec_sh;
          nanoseconds <= nsec_sh;
          pkt_end     <= 32'(byte_cnt);
          wr_ctrl     <= 1'b1;
          state       <= WAIT_RDY;
        end
        WAIT_RDY: begin
          if (wr_ctrl_rdy) state <= IDLE;
        end
        DISCARD: begin
          if (asi_valid && asi_endofpacket) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pkt_begin = 32'd0;
  assign busy      = (state != IDLE) && (state != DISCARD);

`ifdef PKT_CAPT_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic drop_inc;
  assign drop_inc = sop_beat && (state == CAPTURE || state == HANDOFF || state == WAIT_RDY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count   <= '0;
      drop_count  <= '0;
      trunc_count <= '0;
    end else begin
      if (state == HANDOFF)          pkt_count   <= sat_inc(pkt_count);
      if (state == HANDOFF && trunc) trunc_count <= sat_inc(trunc_count);
      if (drop_inc)                  drop_count  <= sat_inc(drop_count);
    end
  end
`else
  logic unused_trunc;
  assign unused_trunc = trunc;
  assign pkt_count    = '0;
  assign drop_count   = '0;
  assign trunc_count  = '0;
`endif

endmodule

// File: tb/tb_pkt_capt_ingress.sv
// Directed bench for pkt_capt_ingress: fixed packet scenarios with hand-computed expectations.
module tb_pkt_capt_ingress;

`ifdef PKT_CAPT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] asi_data = '0;
  logic        asi_valid = 1'b0, asi_startofpacket = 1'b0, asi_endofpacket = 1'b0;
  logic [1:0]  asi_empty = '0;
  logic        capt_en = 1'b1;
  logic [15:0] snaplen = '0;
  logic [31:0] time_sec = 32'd1000, time_nsec = 32'd500;
  logic [31:0] fifo_data;
  logic        fifo_wrreq;
  logic        fifo_full = 1'b0;
  logic        wr_ctrl;
  logic        wr_ctrl_rdy = 1'b0;
  logic [31:0] pkt_begin, pkt_end, seconds, nanoseconds;
  logic        busy;
  logic [31:0] pkt_count, drop_count, trunc_count;

  pkt_capt_ingress dut (
    .clk(clk), .reset(reset),
    .asi_data(asi_data), .asi_valid(asi_valid),
    .asi_startofpacket(asi_startofpacket), .asi_endofpacket(asi_endofpacket),
    .asi_empty(asi_empty), .capt_en(capt_en), .snaplen(snaplen),
    .time_sec(time_sec), .time_nsec(time_nsec),
    .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq), .fifo_full(fifo_full),
    .wr_ctrl(wr_ctrl), .wr_ctrl_rdy(wr_ctrl_rdy),
    .pkt_begin(pkt_begin), .pkt_end(pkt_end),
    .seconds(seconds), .nanoseconds(nanoseconds), .busy(busy),
    .pkt_count(pkt_count), .drop_count(drop_count), .trunc_count(trunc_count)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  int          cyc = 0, nwr = 0, nctrl = 0, last_wr_cyc = 0, ctrl_cyc = 0;
  logic [31:0] last_data = '0;
  logic [31:0] exp_sec = '0, exp_nsec = '0;
  logic        nfull = 1'b0;

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (fifo_wrreq) begin
      nwr = nwr + 1;
      last_wr_cyc = cyc;
      last_data = fifo_data;
    end
    if (wr_ctrl) begin
      nctrl = nctrl + 1;
      ctrl_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic sop, input logic eop, input logic [1:0] emp);
    @(negedge clk);
    asi_valid = 1'b1; asi_data = d; asi_startofpacket = sop; asi_endofpacket = eop;
    asi_empty = emp; fifo_full = nfull;
    time_sec = time_sec + 1; time_nsec = time_nsec + 7;
    if (sop) begin exp_sec = time_sec; exp_nsec = time_nsec; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      asi_valid = 1'b0; asi_startofpacket = 1'b0; asi_endofpacket = 1'b0;
      asi_empty = '0; fifo_full = 1'b0;
    end
  endtask

  task automatic pkt(input int nbeats, input logic [1:0] last_empty, input logic [31:0] base);
    for (int i = 0; i < nbeats; i++)
      beat(base + 32'(i), i == 0, i == nbeats - 1, (i == nbeats - 1) ? last_empty : 2'd0);
  endtask

  task automatic clr();
    @(posedge clk); #1;
    nwr = 0; nctrl = 0;
  endtask

  task automatic rdy();
    @(negedge clk); wr_ctrl_rdy = 1'b1;
    @(negedge clk); wr_ctrl_rdy = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_wrreq", {31'd0, fifo_wrreq}, 32'd0);
    chk("rst_wrctrl", {31'd0, wr_ctrl}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pkt_end", pkt_end, 32'd0);
    chk("rst_seconds", seconds, 32'd0);
    chk("rst_pkt_count", pkt_count, 32'd0);
    reset = 1'b0;
    idle(2);

    // 64-byte packet, no snaplen
    clr();
    pkt(16, 2'd0, 32'hA000_0000);
    idle(3);
    chk("p64_writes", nwr, 32'd16);
    chk("p64_ctrl_n", nctrl, 32'd1);
    chk("p64_ctrl_lat", ctrl_cyc, last_wr_cyc + 1);
    chk("p64_last_data", last_data, 32'hA000_000F);
    chk("p64_pkt_end", pkt_end, 32'd64);
    chk("p64_pkt_begin", pkt_begin, 32'd0);
    chk("p64_sec", seconds, exp_sec);
    chk("p64_nsec", nanoseconds, exp_nsec);
    chk("p64_busy", {31'd0, busy}, 32'd1);
    chk("p64_pkt_count", pkt_count, STATS ? 32'd1 : 32'd0);
    rdy(); idle(1);
    chk("p64_busy_after", {31'd0, busy}, 32'd0);

    // 61-byte packet
    clr();
    pkt(16, 2'd3, 32'hB000_0000);
    idle(3);
    chk("p61_writes", nwr, 32'd16);
    chk("p61_pkt_end", pkt_end, 32'd61);
    chk("p61_sec", seconds, exp_sec);
    rdy(); idle(1);

    // snaplen 20 on a 64-byte packet
    snaplen = 16'd20;
    clr();
    pkt(16, 2'd0, 32'hC000_0000);
    idle(3);
    chk("snap_writes", nwr, 32'd5);
    chk("snap_last_data", last_data, 32'hC000_0004);
    chk("snap_pkt_end", pkt_end, 32'd20);
    chk("snap_trunc", trunc_count, STATS ? 32'd1 : 32'd0);
    rdy(); idle(1);
    snaplen = 16'd0;

    // Packet A captured, packet B arrives during WAIT_RDY, packet C after release
    clr();
    pkt(4, 2'd0, 32'hD000_0000);
    idle(3);
    chk("pa_pkt_end", pkt_end, 32'd16);
    clr();
    pkt(4, 2'd0, 32'hE000_0000);
    idle(2);
    chk("pb_writes", nwr, 32'd0);
    chk("pb_ctrl", nctrl, 32'd0);
    chk("pb_held_end", pkt_end, 32'd16);
    chk("pb_busy", {31'd0, busy}, 32'd1);
    chk("pb_drop", drop_count, STATS ? 32'd1 : 32'd0);
    rdy(); idle(1);
    clr();
    pkt(8, 2'd0, 32'hF000_0000);
    idle(3);
    chk("pc_writes", nwr, 32'd8);
    chk("pc_pkt_end", pkt_end, 32'd32);
    chk("pc_pkt_count", pkt_count, STATS ? 32'd5 : 32'd0);
    rdy(); idle(1);

    // Missing EOP: 3 beats, then a new SOP
    clr();
    beat(32'h1111_0000, 1'b1, 1'b0, 2'd0);
    beat(32'h1111_0001, 1'b0, 1'b0, 2'd0);
    beat(32'h1111_0002, 1'b0, 1'b0, 2'd0);
    chk("noeop_sec_ref", exp_sec, time_sec - 2);
    beat(32'h2222_0000, 1'b1, 1'b0, 2'd0);
    beat(32'h2222_0001, 1'b0, 1'b0, 2'd0);
    beat(32'h2222_0002, 1'b0, 1'b1, 2'd0);
    idle(3);
    chk("noeop_writes", nwr, 32'd3);
    chk("noeop_ctrl", nctrl, 32'd1);
    chk("noeop_pkt_end", pkt_end, 32'd12);
    chk("noeop_trunc", trunc_count, STATS ? 32'd2 : 32'd0);
    chk("noeop_drop", drop_count, STATS ? 32'd2 : 32'd0);
    rdy(); idle(1);

    // capt_en=0 discard, then single-beat SOP+EOP with empty=2
    capt_en = 1'b0;
    clr();
    pkt(4, 2'd0, 32'h3333_0000);
    idle(2);
    chk("disc_writes", nwr, 32'd0);
    chk("disc_ctrl", nctrl, 32'd0);
    chk("disc_busy", {31'd0, busy}, 32'd0);
    capt_en = 1'b1;
    clr();
    beat(32'hCAFE_BABE, 1'b1, 1'b1, 2'd2);
    idle(3);
    chk("single_writes", nwr, 32'd1);
    chk("single_data", last_data, 32'hCAFE_BABE);
    chk("single_pkt_end", pkt_end, 32'd2);
    chk("single_ctrl", nctrl, 32'd1);
    rdy(); idle(1);

    // FIFO full on the middle two beats of a 4-beat packet
    clr();
    nfull = 1'b0; beat(32'h4444_0000, 1'b1, 1'b0, 2'd0);
    nfull = 1'b1; beat(32'h4444_0001, 1'b0, 1'b0, 2'd0);
    beat(32'h4444_0002, 1'b0, 1'b0, 2'd0);
    nfull = 1'b0; beat(32'h4444_0003, 1'b0, 1'b1, 2'd0);
    idle(3);
    chk("full_writes", nwr, 32'd2);
    chk("full_last_data", last_data, 32'h4444_0003);
    chk("full_pkt_end", pkt_end, 32'd8);
    chk("full_trunc", trunc_count, STATS ? 32'd3 : 32'd0);
    chk("full_pkt_count", pkt_count, STATS ? 32'd8 : 32'd0);
    rdy(); idle(2);
    chk("end_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
